rs_ff_controller: RTL and testbench

RS_FF_CONTROLLER -- requirements
Module: rs_ff_controller

---
 rtl/rs_ff_controller.sv | 104 ++++++++++
 tb/tb_rs_ff_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_ff_controller.sv
// Handshaked controller that pulses s or r into an external RS flip-flop,
// then confirms the result through the q feedback with a bounded wait.
module rs_ff_controller #(
    parameter int PULSE_CYC = 2,
    parameter int TIMEOUT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       clr_req,
    input  logic       q,
    output logic       s,
    output logic       r,
    output logic       set_ack,
    output logic       clr_ack,
    output logic       busy,
    output logic       err,
    output logic [7:0] op_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ACK} state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] TMO_LAST   = 4'(TIMEOUT - 1);

    state_t     r_state;
    logic [3:0] r_pulse_cnt;
    logic [3:0] r_wait_cnt;
    logic       r_op_set;
    logic       r_last_set;

    logic w_any_req;
    logic w_grant_set;
    logic w_q_match;

    // On a tie, the type opposite to the last grant wins.
    assign w_any_req   = set_req | clr_req;
    assign w_grant_set = set_req & (~clr_req | ~r_last_set);
    assign w_q_match   = (q == r_op_set);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pulse_cnt <= 4'd0;
            r_wait_cnt  <= 4'd0;
            r_op_set    <= 1'b0;
            r_last_set  <= 1'b0;
            s           <= 1'b0;
            r           <= 1'b0;
            set_ack     <= 1'b0;
            clr_ack     <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            op_cnt      <= 8'd0;
        end else begin
            set_ack <= 1'b0;
            clr_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state     <= DRIVE;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        r_op_set    <= w_grant_set;
                        r_last_set  <= w_grant_set;
                        s           <= w_grant_set;
                        r           <= ~w_grant_set;
                        r_pulse_cnt <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        s          <= 1'b0;
                        r          <= 1'b0;
                        r_state    <= CHECK;
                        r_wait_cnt <= 4'd0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    // Leave on confirmation or once the wait budget is spent.
                    if (w_q_match || (r_wait_cnt == TMO_LAST)) begin
                        r_state <= ACK;
                        err     <= ~w_q_match;
                        set_ack <= r_op_set;
                        clr_ack <= ~r_op_set;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    if (!err) begin
                        op_cnt <= op_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_ff_controller.sv
// Directed bench for rs_ff_controller with a one-cycle-delay RS flip-flop model on q.
module tb_rs_ff_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       q = 1'b0;
    logic       s, r, set_ack, clr_ack, busy, err;
    logic [7:0] op_cnt;

    logic       q_tie0 = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_overlap = 0;

    rs_ff_controller #(.PULSE_CYC(2), .TIMEOUT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .clr_req (clr_req),
        .q       (q),
        .s       (s),
        .r       (r),
        .set_ack (set_ack),
        .clr_ack (clr_ack),
        .busy    (busy),
        .err     (err),
        .op_cnt  (op_cnt)
    );

    always #5 clk = ~clk;

    // External RS flip-flop: q follows s/r one cycle later.
    always @(posedge clk) begin
        if (q_tie0)  q <= 1'b0;
        else if (s)  q <= 1'b1;
        else if (r)  q <= 1'b0;
    end

    always @(negedge clk) begin
        if (s && r) n_overlap++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic do_op(input bit is_set);
        bit got = 0;
        if (is_set) set_req = 1'b1;
        else        clr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if ((is_set && set_ack) || (!is_set && clr_ack)) begin
                got = 1;
                break;
            end
        end
        chk("op_ack", 32'(got), 32'd1);
        chk("op_err", 32'(err), 32'd0);
        set_req = 1'b0;
        clr_req = 1'b0;
        tick;
    endtask

    initial begin
        bit seen;

        // Reset state
        tick;
        tick;
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_acks", 32'({set_ack, clr_ack}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_opcnt", 32'(op_cnt), 32'd0);
        rst_n = 1'b1;
        tick;

        // Single set with latency check
        set_req = 1'b1;
        tick;
        chk("set_c1_s", 32'(s), 32'd1);
        chk("set_c1_r", 32'(r), 32'd0);
        chk("set_c1_busy", 32'(busy), 32'd1);
        tick;
        chk("set_c2_s", 32'(s), 32'd1);
        tick;
        chk("set_c3_s", 32'(s), 32'd0);
        chk("set_c3_q", 32'(q), 32'd1);
        chk("set_c3_ack", 32'(set_ack), 32'd0);
        tick;
        chk("set_c4_ack", 32'(set_ack), 32'd1);
        chk("set_c4_err", 32'(err), 32'd0);
        chk("set_c4_cnt", 32'(op_cnt), 32'd0);
        set_req = 1'b0;
        tick;
        chk("set_c5_ack", 32'(set_ack), 32'd0);
        chk("set_c5_busy", 32'(busy), 32'd0);
        chk("set_c5_cnt", 32'(op_cnt), 32'd1);

        // Tie after reset: set first, then clear
        do_reset;
        set_req = 1'b1;
        clr_req = 1'b1;
        tick;
        chk("tie_c1_s", 32'(s), 32'd1);
        chk("tie_c1_r", 32'(r), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (set_ack) begin
                seen = 1;
                break;
            end
        end
        chk("tie_set_ack", 32'(seen), 32'd1);
        chk("tie_no_clr_yet", 32'(clr_ack), 32'd0);
        set_req = 1'b0;
        tick;
        chk("tie_gap_sr", 32'({s, r}), 32'd0);
        chk("tie_gap_busy", 32'(busy), 32'd0);
        tick;
        chk("tie_clr_r", 32'(r), 32'd1);
        chk("tie_clr_s", 32'(s), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (clr_ack) begin
                seen = 1;
                break;
            end
        end
        chk("tie_clr_ack", 32'(seen), 32'd1);
        clr_req = 1'b0;
        tick;
        chk("tie_cnt", 32'(op_cnt), 32'd2);
        chk("tie_q", 32'(q), 32'd0);

        // Timeout with q stuck low, then a grant clears err
        q_tie0 = 1'b1;
        set_req = 1'b1;
        tick;
        chk("tmo_c1_s", 32'(s), 32'd1);
        tick;
        tick;
        chk("tmo_c3_s", 32'(s), 32'd0);
        chk("tmo_c3_ack", 32'(set_ack), 32'd0);
        tick;
        chk("tmo_c4_ack", 32'(set_ack), 32'd0);
        tick;
        chk("tmo_c5_ack", 32'(set_ack), 32'd0);
        chk("tmo_c5_busy", 32'(busy), 32'd1);
        tick;
        chk("tmo_c6_ack", 32'(set_ack), 32'd1);
        chk("tmo_c6_err", 32'(err), 32'd1);
        set_req = 1'b0;
        tick;
        chk("tmo_c7_cnt", 32'(op_cnt), 32'd2);
        chk("tmo_c7_err", 32'(err), 32'd1);
        chk("tmo_c7_busy", 32'(busy), 32'd0);
        clr_req = 1'b1;
        tick;
        chk("tmo_grant_err", 32'(err), 32'd0);
        chk("tmo_grant_r", 32'(r), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (clr_ack) begin
                seen = 1;
                break;
            end
        end
        chk("tmo_clr_ack", 32'(seen), 32'd1);
        chk("tmo_clr_err", 32'(err), 32'd0);
        clr_req = 1'b0;
        tick;
        chk("tmo_clr_cnt", 32'(op_cnt), 32'd3);
        q_tie0 = 1'b0;

        // Abort by reset in the middle of a set drive
        do_reset;
        chk("abt_cnt0", 32'(op_cnt), 32'd0);
        set_req = 1'b1;
        tick;
        chk("abt_c1_s", 32'(s), 32'd1);
        tick;
        rst_n = 1'b0;
        set_req = 1'b0;
        tick;
        chk("abt_c3_s", 32'(s), 32'd0);
        chk("abt_c3_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (set_ack || clr_ack) seen = 1;
        end
        chk("abt_no_ack", 32'(seen), 32'd0);
        chk("abt_cnt", 32'(op_cnt), 32'd0);

        // 256 alternating successful operations wrap op_cnt
        for (int i = 0; i < 255; i++) do_op(i[0]);
        chk("wrap_255", 32'(op_cnt), 32'd255);
        do_op(1'b1);
        chk("wrap_0", 32'(op_cnt), 32'd0);

        chk("s_r_exclusive", 32'(n_overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
